// File: rtl/addsub_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | addsub_pkg                                                           |
// | Shared width, opcode and FSM-state definitions for addsub_acc.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package addsub_pkg;

   localparam int WIDTH = 4;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_ADD  = 2'b01,
      OP_SUB  = 2'b10,
      OP_CLR  = 2'b11
   } op_e;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;

endpackage : addsub_pkg
`default_nettype wire

// File: rtl/add_sub.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | add_sub                                                              |
// | 4-bit adder/subtractor: s = a + b (swi=0) or a - b (swi=1).          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module add_sub (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       swi,
   output logic [3:0] s,
   output logic       c
);

   logic [3:0] bx;
   logic [4:0] total;

   // Subtraction is a + ~b + 1, so c=1 means no borrow.
   assign bx    = b ^ {4{swi}};
   assign total = {1'b0, a} + {1'b0, bx} + {4'b0000, swi};
   assign s     = total[3:0];
   assign c     = total[4];

endmodule : add_sub
`default_nettype wire

// File: rtl/addsub_acc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | addsub_acc                                                           |
// | Handshaked accumulator around add_sub with registered result/flags.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module addsub_acc
   import addsub_pkg::*;
#(
   parameter int WIDTH    = addsub_pkg::WIDTH,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_acc,
   output logic             out_c,
   output logic             out_v,
   output logic             out_z,
   output logic             out_n
);

   generate
      if (WIDTH != 4) begin : g_bad_width
         $error("addsub_acc: WIDTH must be 4 to match add_sub");
      end
   endgenerate

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             c_q, c_d;
   logic             v_q, v_d;
   logic             z_q, z_d;
   logic             n_q, n_d;

   logic             accept;
   logic             swi;
   logic [WIDTH-1:0] bx;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             ovf;

   assign swi = (in_op == OP_SUB);
   assign bx  = in_b ^ {WIDTH{swi}};

   add_sub u_add_sub (
      .a   (acc_q),
      .b   (in_b),
      .swi (swi),
      .s   (sum),
      .c   (carry)
   );

   assign ovf = (acc_q[WIDTH-1] == bx[WIDTH-1]) & (sum[WIDTH-1] != acc_q[WIDTH-1]);

   // A held result can be replaced in the same cycle it is consumed.
   assign in_ready = (state_q == IDLE) | out_ready;
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      c_d     = c_q;
      v_d     = v_q;
      z_d     = z_q;
      n_d     = n_q;

      if (accept) begin
         state_d = HOLD;
         case (in_op)
            OP_LOAD: begin
               acc_d = in_b;
               c_d   = 1'b0;
               v_d   = 1'b0;
            end
            OP_ADD: begin
               acc_d = (SATURATE && carry) ? {WIDTH{1'b1}} : sum;
               c_d   = carry;
               v_d   = ovf;
            end
            OP_SUB: begin
               acc_d = (SATURATE && !carry) ? {WIDTH{1'b0}} : sum;
               c_d   = carry;
               v_d   = ovf;
            end
            default: begin
               acc_d = {WIDTH{1'b0}};
               c_d   = 1'b0;
               v_d   = 1'b0;
            end
         endcase
         z_d = (acc_d == {WIDTH{1'b0}});
         n_d = acc_d[WIDTH-1];
      end else if ((state_q == HOLD) && out_ready) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= {WIDTH{1'b0}};
         c_q     <= 1'b0;
         v_q     <= 1'b0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         c_q     <= c_d;
         v_q     <= v_d;
         z_q     <= z_d;
         n_q     <= n_d;
      end
   end

   assign out_valid = (state_q == HOLD);
   assign out_acc   = acc_q;
   assign out_c     = c_q;
   assign out_v     = v_q;
   assign out_z     = z_q;
   assign out_n     = n_q;

endmodule : addsub_acc
`default_nettype wire

// File: tb/tb_addsub_acc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_addsub_acc                                                        |
// | Directed + random check of wrap and saturating addsub_acc instances. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_addsub_acc;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [1:0] in_op;
   logic [3:0] in_b;
   logic       out_ready;

   logic       in_ready  [2];
   logic       out_valid [2];
   logic [3:0] out_acc   [2];
   logic       out_c     [2];
   logic       out_v     [2];
   logic       out_z     [2];
   logic       out_n     [2];

   int n_total = 0;
   int n_bad   = 0;

   // Reference state: index 0 wraps, index 1 saturates.
   int m_acc [2];
   bit m_c   [2];
   bit m_v   [2];
   bit m_z   [2];
   bit m_n   [2];
   bit m_valid;

   always #5 clk = ~clk;

   addsub_acc #(.WIDTH(4), .SATURATE(1'b0)) u_dut_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
      .in_op(in_op), .in_b(in_b), .out_valid(out_valid[0]), .out_ready(out_ready),
      .out_acc(out_acc[0]), .out_c(out_c[0]), .out_v(out_v[0]),
      .out_z(out_z[0]), .out_n(out_n[0])
   );

   addsub_acc #(.WIDTH(4), .SATURATE(1'b1)) u_dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
      .in_op(in_op), .in_b(in_b), .out_valid(out_valid[1]), .out_ready(out_ready),
      .out_acc(out_acc[1]), .out_c(out_c[1]), .out_v(out_v[1]),
      .out_z(out_z[1]), .out_n(out_n[1])
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
      end
   endtask

   function automatic int to_signed4(input int x);
      return (x > 7) ? x - 16 : x;
   endfunction

   // Arithmetic model of one accepted command for one instance.
   task automatic model_op(input int k, input bit sat, input int op, input int b);
      int a, r, sr;
      a = m_acc[k];
      case (op)
         0: begin m_acc[k] = b; m_c[k] = 0; m_v[k] = 0; end
         1: begin
            r  = a + b;
            sr = to_signed4(a) + to_signed4(b);
            m_c[k]   = (r > 15);
            m_v[k]   = (sr > 7) || (sr < -8);
            m_acc[k] = (sat && r > 15) ? 15 : (r & 15);
         end
         2: begin
            r  = a - b;
            sr = to_signed4(a) - to_signed4(b);
            m_c[k]   = (r >= 0);
            m_v[k]   = (sr > 7) || (sr < -8);
            m_acc[k] = (sat && r < 0) ? 0 : (r & 15);
         end
         default: begin m_acc[k] = 0; m_c[k] = 0; m_v[k] = 0; end
      endcase
      m_z[k] = (m_acc[k] == 0);
      m_n[k] = (m_acc[k] >= 8);
   endtask

   // Drive one cycle of inputs, check ready before the edge and outputs after.
   task automatic step(input bit r, input bit iv, input int op, input int b, input bit ordy);
      bit acc_ok;
      @(negedge clk);
      rst       = r;
      in_valid  = iv;
      in_op     = 2'(op);
      in_b      = 4'(b);
      out_ready = ordy;
      #1;
      for (int k = 0; k < 2; k++)
         chk($sformatf("in_ready[%0d]", k), int'(in_ready[k]), int'(!m_valid || ordy));
      acc_ok = iv && (!m_valid || ordy);
      @(posedge clk);
      if (r) begin
         for (int k = 0; k < 2; k++) begin
            m_acc[k] = 0; m_c[k] = 0; m_v[k] = 0; m_z[k] = 0; m_n[k] = 0;
         end
         m_valid = 0;
      end else if (acc_ok) begin
         model_op(0, 1'b0, op, b);
         model_op(1, 1'b1, op, b);
         m_valid = 1;
      end else if (m_valid && ordy) begin
         m_valid = 0;
      end
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("out_valid[%0d]", k), int'(out_valid[k]), int'(m_valid));
         chk($sformatf("out_acc[%0d]", k),   int'(out_acc[k]),   m_acc[k]);
         chk($sformatf("out_c[%0d]", k),     int'(out_c[k]),     int'(m_c[k]));
         chk($sformatf("out_v[%0d]", k),     int'(out_v[k]),     int'(m_v[k]));
         chk($sformatf("out_z[%0d]", k),     int'(out_z[k]),     int'(m_z[k]));
         chk($sformatf("out_n[%0d]", k),     int'(out_n[k]),     int'(m_n[k]));
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_b = 4'd0; out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_acc[k] = 0; m_c[k] = 0; m_v[k] = 0; m_z[k] = 0; m_n[k] = 0;
      end
      m_valid = 0;

      step(1, 0, 0, 0, 0);
      step(1, 1, 0, 9, 1);

      // LOAD 5, ADD 3 -> 8 with signed overflow.
      step(0, 1, 0, 5, 1);
      step(0, 1, 1, 3, 1);
      chk("add_overflow_acc", int'(out_acc[0]), 8);
      chk("add_overflow_v",   int'(out_v[0]),   1);
      step(0, 0, 0, 0, 1);

      // LOAD 3, SUB 5 -> E with borrow; SUB E -> 0.
      step(0, 1, 0, 3, 1);
      step(0, 1, 2, 5, 1);
      chk("sub_borrow_acc", int'(out_acc[0]), 14);
      step(0, 1, 2, 14, 1);
      chk("sub_zero_z", int'(out_z[0]), 1);

      // LOAD F, ADD 1: wrap vs saturate; then CLR, SUB 1.
      step(0, 1, 0, 15, 1);
      step(0, 1, 1, 1, 1);
      chk("wrap_acc", int'(out_acc[0]), 0);
      chk("sat_acc",  int'(out_acc[1]), 15);
      step(0, 1, 3, 7, 1);
      step(0, 1, 2, 1, 1);
      chk("sat_floor_acc", int'(out_acc[1]), 0);
      chk("wrap_under_acc", int'(out_acc[0]), 15);

      // Backpressure for 4 cycles, then release.
      step(0, 1, 0, 6, 1);
      for (int i = 0; i < 4; i++) step(0, 1, 1, 2, 0);
      step(0, 1, 1, 2, 1);
      step(0, 0, 0, 0, 1);

      // Streaming ADD 1 x16 from zero.
      step(0, 1, 3, 0, 1);
      for (int i = 0; i < 16; i++) step(0, 1, 1, 1, 1);
      step(0, 0, 0, 0, 1);

      // Reset while holding an unconsumed result.
      step(0, 1, 0, 9, 0);
      step(0, 1, 1, 1, 0);
      step(1, 1, 1, 1, 0);
      step(0, 0, 0, 0, 1);

      // Random traffic with occasional reset.
      for (int i = 0; i < 3000; i++)
         step(($urandom_range(0, 99) < 2), ($urandom_range(0, 3) != 0),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
              ($urandom_range(0, 3) != 0));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_addsub_acc
`default_nettype wire
